tiny_control_sequencer: RTL and testbench
=========================================

Name: tiny_control_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the tiny_processor datapath: accumulator, ALU, register file and 4-bit PC.
- Owns the PC and instruction register, and fetches from instruction memory over a req/ack handshake.
- Emits one-cycle ALU, register and accumulator strobes; resolves branches, CALL/RET through a small return stack, and HALT.

Parameters:
- PC_WIDTH, 4, width of PC, start_address and branch targets; PC wraps modulo 2^PC_WIDTH.
- STACK_DEPTH, 2, number of return-stack entries for CALL/RET (1..4).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  in IDLE, begin execution at start_address.
- start_address  in  PC_WIDTH  PC value loaded on start.
- imem_req  out  1  fetch request, held until imem_ack.
- imem_addr  out  PC_WIDTH  fetch address, equal to pc while imem_req=1.
- imem_ack  in  1  fetch complete; imem_data is valid this cycle.
- imem_data  in  8  instruction word.
- zero_flag  in  1  ACC==0 from datapath.
- cb_flag  in  1  carry/borrow from datapath.
- pc  out  PC_WIDTH  current program counter.
- ir_out  out  8  instruction register.
- alu_enable  out  1  one-cycle ALU operate strobe.
- alu_opcode  out  4  ALU operation, equal to ir[7:4] during alu_enable.
- reg_write  out  1  one-cycle strobe: write ACC to register reg_sel.
- acc_load  out  1  one-cycle strobe: load ACC.
- acc_src  out  1  ACC source: 0 = ALU result, 1 = register reg_sel.
- reg_sel  out  4  register index, equal to ir[3:0].
- state_out  out  3  FSM state encoding.
- halted  out  1  high in HALT state.
- fault  out  1  high in FAULT state.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - State IDLE; pc=0; ir=0x00; stack empty.
  - All strobes, imem_req, halted and fault = 0.
  - imem_req drops immediately, even mid-fetch.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4, FAULT=5.
- IDLE: when start=1, pc<=start_address and go to FETCH. Otherwise stay in IDLE.
- FETCH:
  - imem_req=1 and imem_addr=pc, both stable until ack.
  - On imem_ack=1: ir<=imem_data, go to DECODE.
  - Same-cycle ack is allowed; any number of wait cycles is allowed.
  - imem_ack outside FETCH is ignored.
- DECODE: one cycle, no strobes; then go to EXEC.
- EXEC: one cycle; strobes are asserted only here; then go to FETCH unless stated otherwise below.
- Minimum instruction latency: 3 cycles.
- Instruction decode (op = ir[7:4], operand = ir[3:0]):
  - 0x0 NOP: pc+1.
  - 0x1-0x7 ALU ops (ADD, SUB, AND, OR, XOR, SHL, SHR): alu_enable=1, alu_opcode=op, acc_load=1, acc_src=0; pc+1.
  - 0x8 MOVR (ACC->Rn): reg_write=1; pc+1.
  - 0x9 MOVA (Rn->ACC): acc_load=1, acc_src=1; pc+1.
  - 0xA, 0xB reserved: NOP.
  - 0xC BRZ: pc<=operand if zero_flag=1, else pc+1.
  - 0xD BRC: pc<=operand if cb_flag=1, else pc+1.
  - 0xE CALL: push pc+1, then pc<=operand. If the stack is full: go to FAULT, pc unchanged.
  - 0xF with operand 0x0, RET: pc<=pop. If the stack is empty: go to FAULT, pc unchanged.
  - 0xF with operand 0xF, HALT: go to HALT, pc unchanged.
  - 0xF with any other operand: NOP.
- Flags are sampled in the EXEC cycle only.
- pc+1 wraps from 2^PC_WIDTH-1 to 0. Pushed return addresses wrap the same way.
- HALT and FAULT are sticky; only reset leaves them. start is ignored there and in all non-IDLE states.
- Outputs are registered except imem_addr, which mirrors pc.
- state_out, halted and fault are valid every cycle.

Test Plan:
- Program 0x00:MOVA R1, 0x01:ADD R2 (0x12), 0x02:HALT (0xFF); zero-wait ack -> strobes exactly on EXEC cycles; halted=1 at cycle 9 after start; pc=0x2.
- BRZ 0x5 (0xC5) with zero_flag=1, then BRZ 0x5 with zero_flag=0 at pc=0x3 -> first gives next imem_addr=0x5, second gives 0x4.
- CALL 0x8 at pc=0x2, RET at 0x8 -> fetch addresses 0x2, 0x8, 0x3; stack empty afterwards.
- Three nested CALLs with STACK_DEPTH=2 -> third CALL enters FAULT, fault=1, pc holds the CALL target of the second; RET at reset state -> FAULT.
- imem_ack delayed 3 cycles -> imem_req and imem_addr held constant; ir updates only on the ack cycle; NOP at pc=0xF -> next fetch from 0x0.
- reset pulled low during FETCH wait -> imem_req=0 the same cycle; state IDLE; pc=0; restart with start_address=0x4 fetches 0x4.

Source files
------------

// File: rtl/tiny_control_sequencer.sv
// tiny_control_sequencer: fetch/decode/execute controller for tiny_processor.
// Owns pc/ir, fetches over req/ack, strobes datapath in EXEC, CALL/RET stack.
//
// Ports:
//   clk, reset (async, active-low)
//   start, start_address          - launch from IDLE
//   imem_req/addr/ack/data        - instruction fetch handshake
//   zero_flag, cb_flag            - datapath flags, sampled in EXEC
//   pc, ir_out, state_out         - architectural / debug state
//   alu_enable, alu_opcode        - ALU strobe and operation
//   reg_write, acc_load, acc_src  - register/accumulator strobes
//   reg_sel                       - register index (ir[3:0])
//   halted, fault                 - sticky terminal states
module tiny_control_sequencer #(
    parameter int PC_WIDTH    = 4,
    parameter int STACK_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [PC_WIDTH-1:0] start_address,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [7:0]          imem_data,
    input  logic                zero_flag,
    input  logic                cb_flag,
    output logic [PC_WIDTH-1:0] pc,
    output logic [7:0]          ir_out,
    output logic                alu_enable,
    output logic [3:0]          alu_opcode,
    output logic                reg_write,
    output logic                acc_load,
    output logic                acc_src,
    output logic [3:0]          reg_sel,
    output logic [2:0]          state_out,
    output logic                halted,
    output logic                fault
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t              state, state_nx;
    logic [PC_WIDTH-1:0] pc_nx, pc_inc, operand_pc, ret_pc;
    logic [7:0]          ir, ir_nx;
    logic [SP_W-1:0]     sp, sp_nx, sp_top;
    logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
    logic                push;
    logic [3:0]          op, operand;
    logic                is_alu, in_dec;
    logic                alu_en_nx, reg_wr_nx, acc_ld_nx, acc_src_nx;

    assign op         = ir[7:4];
    assign operand    = ir[3:0];
    assign pc_inc     = pc + PC_WIDTH'(1);
    assign operand_pc = PC_WIDTH'(operand);
    assign sp_top     = sp - SP_W'(1);
    assign ret_pc     = stack[IDX_W'(sp_top)];

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir;
        sp_nx    = sp;
        push     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    pc_nx    = start_address;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_nx    = imem_data;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: state_nx = S_EXEC;
            S_EXEC: begin
                state_nx = S_FETCH;
                pc_nx    = pc_inc;
                case (op)
                    4'hC: if (zero_flag) pc_nx = operand_pc;
                    4'hD: if (cb_flag) pc_nx = operand_pc;
                    4'hE: begin
                        if (sp == SP_FULL) begin
                            state_nx = S_FAULT;
                            pc_nx    = pc;
                        end else begin
                            push  = 1'b1;
                            sp_nx = sp + SP_W'(1);
                            pc_nx = operand_pc;
                        end
                    end
                    4'hF: begin
                        if (operand == 4'h0) begin
                            if (sp == '0) begin
                                state_nx = S_FAULT;
                                pc_nx    = pc;
                            end else begin
                                pc_nx = ret_pc;
                                sp_nx = sp_top;
                            end
                        end else if (operand == 4'hF) begin
                            state_nx = S_HALT;
                            pc_nx    = pc;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;  // HALT and FAULT hold until reset
        endcase
    end

    // Strobes are registered from DECODE so they are high exactly in EXEC.
    always_comb begin
        is_alu     = (op != 4'h0) && !op[3];
        in_dec     = (state == S_DECODE);
        alu_en_nx  = in_dec && is_alu;
        reg_wr_nx  = in_dec && (op == 4'h8);
        acc_ld_nx  = in_dec && (is_alu || op == 4'h9);
        acc_src_nx = in_dec && (op == 4'h9);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir         <= '0;
            sp         <= '0;
            alu_enable <= 1'b0;
            reg_write  <= 1'b0;
            acc_load   <= 1'b0;
            acc_src    <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            ir         <= ir_nx;
            sp         <= sp_nx;
            alu_enable <= alu_en_nx;
            reg_write  <= reg_wr_nx;
            acc_load   <= acc_ld_nx;
            acc_src    <= acc_src_nx;
            if (push) begin
                stack[IDX_W'(sp)] <= pc_inc;
            end
        end
    end

    assign imem_req   = (state == S_FETCH);
    assign imem_addr  = pc;
    assign ir_out     = ir;
    assign alu_opcode = op;
    assign reg_sel    = operand;
    assign state_out  = state;
    assign halted     = (state == S_HALT);
    assign fault      = (state == S_FAULT);
endmodule

// File: tb/tb_tiny_control_sequencer.sv
// Bench for tiny_control_sequencer: memory responder with a fetch-address
// scoreboard and an EXEC-cycle strobe scoreboard, one task per scenario.
module tb_tiny_control_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] start_address = 4'h0;
    logic       imem_req;
    logic [3:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic       zero_flag = 1'b0;
    logic       cb_flag = 1'b0;
    logic [3:0] pc;
    logic [7:0] ir_out;
    logic       alu_enable;
    logic [3:0] alu_opcode;
    logic       reg_write;
    logic       acc_load;
    logic       acc_src;
    logic [3:0] reg_sel;
    logic [2:0] state_out;
    logic       halted;
    logic       fault;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [16];
    logic [3:0]  fetch_q [$];
    logic [19:0] exec_q [$];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [7:0]  last_ir = 8'h00;
    logic [3:0]  held_addr = 4'h0;

    tiny_control_sequencer #(.PC_WIDTH(4), .STACK_DEPTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .start_address(start_address),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_data(imem_data),
        .zero_flag(zero_flag),
        .cb_flag(cb_flag),
        .pc(pc),
        .ir_out(ir_out),
        .alu_enable(alu_enable),
        .alu_opcode(alu_opcode),
        .reg_write(reg_write),
        .acc_load(acc_load),
        .acc_src(acc_src),
        .reg_sel(reg_sel),
        .state_out(state_out),
        .halted(halted),
        .fault(fault)
    );

    always #5 clk = ~clk;

    // Expected EXEC-cycle view of one instruction:
    // {alu_enable, reg_write, acc_load, acc_src, ir, reg_sel, alu_opcode}
    function automatic logic [19:0] exp_exec(input logic [7:0] i);
        logic [3:0] o;
        logic       alu, rw, al, as;
        o   = i[7:4];
        alu = (o >= 4'h1) && (o <= 4'h7);
        rw  = (o == 4'h8);
        al  = alu || (o == 4'h9);
        as  = (o == 4'h9);
        return {alu, rw, al, as, i, i[3:0], alu ? o : 4'h0};
    endfunction

    task automatic expect_instr(input logic [3:0] a, input logic [7:0] i);
        fetch_q.push_back(a);
        exec_q.push_back(exp_exec(i));
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        fetch_q.delete();
        exec_q.delete();
        last_ir = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_prog(input logic [3:0] sa, input int max_cyc,
                            output bit timed_out);
        int n = 0;
        @(negedge clk);
        start_address = sa;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(halted === 1'b1 || fault === 1'b1) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        timed_out = (n >= max_cyc);
    endtask

    // Memory responder: acks after ack_delay wait cycles, checks fetch order
    // and that address and ir hold steady while waiting.
    initial begin
        logic [3:0] ea;
        forever begin
            @(negedge clk);
            if (reset && imem_req) begin
                if (wait_cnt > 0) begin
                    checks++;
                    if (imem_addr !== held_addr) begin
                        failures++;
                        $display("FAIL addr_hold: got %h want %h", imem_addr, held_addr);
                    end
                    checks++;
                    if (ir_out !== last_ir) begin
                        failures++;
                        $display("FAIL ir_hold: got %h want %h", ir_out, last_ir);
                    end
                end else begin
                    held_addr = imem_addr;
                end
                if (wait_cnt == ack_delay) begin
                    imem_ack = 1'b1;
                    imem_data = mem[imem_addr];
                    last_ir = mem[imem_addr];
                    wait_cnt = 0;
                    checks++;
                    if (fetch_q.size() == 0) begin
                        failures++;
                        $display("FAIL fetch_addr: got %h want none", imem_addr);
                    end else begin
                        ea = fetch_q.pop_front();
                        if (imem_addr !== ea) begin
                            failures++;
                            $display("FAIL fetch_addr: got %h want %h", imem_addr, ea);
                        end
                    end
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // EXEC monitor: strobes match the scoreboard in EXEC and are low elsewhere.
    initial begin
        logic [19:0] e, a;
        forever begin
            @(negedge clk);
            a = {alu_enable, reg_write, acc_load, acc_src, ir_out, reg_sel,
                 alu_enable ? alu_opcode : 4'h0};
            checks++;
            if (state_out == 3'd3) begin
                if (exec_q.size() == 0) begin
                    failures++;
                    $display("FAIL exec: got %h want none", a);
                end else begin
                    e = exec_q.pop_front();
                    if (a !== e) begin
                        failures++;
                        $display("FAIL exec: got %h want %h", a, e);
                    end
                end
            end else if ({alu_enable, reg_write, acc_load} !== 3'b000) begin
                failures++;
                $display("FAIL strobe_idle: got %b want 000 state %0d",
                         {alu_enable, reg_write, acc_load}, state_out);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({state_out, pc, ir_out} !== 15'h0) begin
            failures++;
            $display("FAIL reset_state: got %h/%h/%h want 0/0/00", state_out, pc, ir_out);
        end
        checks++;
        if ({imem_req, halted, fault, alu_enable, reg_write, acc_load, acc_src} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outs: got %b want 0000000",
                     {imem_req, halted, fault, alu_enable, reg_write, acc_load, acc_src});
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (state_out !== 3'd0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: got state %0d req %b want 0 0", state_out, imem_req);
        end
    endtask

    task automatic test_program();
        do_reset();
        fill_mem();
        ack_delay = 0;
        mem[0] = 8'h91;
        mem[1] = 8'h12;
        mem[2] = 8'hFF;
        expect_instr(4'h0, 8'h91);
        expect_instr(4'h1, 8'h12);
        expect_instr(4'h2, 8'hFF);
        @(negedge clk);
        start_address = 4'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (state_out !== 3'd1 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL prog_fetch0: got state %0d req %b want 1 1", state_out, imem_req);
        end
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 8) begin
                checks++;
                if (halted !== 1'b0) begin
                    failures++;
                    $display("FAIL prog_early_halt: got %b want 0", halted);
                end
            end
        end
        checks++;
        if (halted !== 1'b1 || state_out !== 3'd4 || pc !== 4'h2) begin
            failures++;
            $display("FAIL prog_halt: got h%b s%0d pc%h want h1 s4 pc2", halted, state_out, pc);
        end
        checks++;
        if (fetch_q.size() != 0 || exec_q.size() != 0) begin
            failures++;
            $display("FAIL prog_drain: got %0d/%0d left want 0/0", fetch_q.size(), exec_q.size());
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (state_out !== 3'd4 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL halt_sticky: got s%0d req %b want s4 req 0", state_out, imem_req);
        end
    endtask

    task automatic test_branch();
        logic [3:0] sa  [4] = '{4'h0, 4'h3, 4'h6, 4'h6};
        logic [7:0] ins [4] = '{8'hC5, 8'hC5, 8'hDA, 8'hDA};
        logic       zf  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       cf  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] tg  [4] = '{4'h5, 4'h4, 4'hA, 4'h7};
        bit to;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            fill_mem();
            mem[sa[k]] = ins[k];
            zero_flag = zf[k];
            cb_flag = cf[k];
            expect_instr(sa[k], ins[k]);
            expect_instr(tg[k], 8'hFF);
            run_prog(sa[k], 50, to);
            checks++;
            if (to || halted !== 1'b1 || pc !== tg[k]) begin
                failures++;
                $display("FAIL branch_%0d: got pc %h halted %b want pc %h halted 1",
                         k, pc, halted, tg[k]);
            end
            checks++;
            if (fetch_q.size() != 0 || exec_q.size() != 0) begin
                failures++;
                $display("FAIL branch_drain_%0d: got %0d/%0d want 0/0",
                         k, fetch_q.size(), exec_q.size());
            end
        end
        zero_flag = 1'b0;
        cb_flag = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] prog [14] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                                 8'h77, 8'h85, 8'h93, 8'hA0, 8'hB0, 8'hF3,
                                 8'h00, 8'hFF};
        bit to;
        do_reset();
        fill_mem();
        for (int i = 0; i < 14; i++) begin
            mem[i] = prog[i];
            expect_instr(4'(i), prog[i]);
        end
        run_prog(4'h0, 100, to);
        checks++;
        if (to || halted !== 1'b1 || pc !== 4'hD) begin
            failures++;
            $display("FAIL b2b_halt: got pc %h halted %b want pc d halted 1", pc, halted);
        end
        checks++;
        if (fetch_q.size() != 0 || exec_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain: got %0d/%0d want 0/0", fetch_q.size(), exec_q.size());
        end
    endtask

    task automatic test_call_ret();
        bit to;
        do_reset();
        fill_mem();
        mem[2] = 8'hE8;
        mem[8] = 8'hF0;
        mem[3] = 8'hF0;
        expect_instr(4'h2, 8'hE8);
        expect_instr(4'h8, 8'hF0);
        expect_instr(4'h3, 8'hF0);
        run_prog(4'h2, 50, to);
        checks++;
        if (to || fault !== 1'b1 || halted !== 1'b0 || pc !== 4'h3 || state_out !== 3'd5) begin
            failures++;
            $display("FAIL call_ret: got f%b h%b pc %h s%0d want f1 h0 pc 3 s5",
                     fault, halted, pc, state_out);
        end
        checks++;
        if (fetch_q.size() != 0 || exec_q.size() != 0) begin
            failures++;
            $display("FAIL call_drain: got %0d/%0d want 0/0", fetch_q.size(), exec_q.size());
        end
    endtask

    task automatic test_stack_overflow();
        bit to;
        do_reset();
        fill_mem();
        mem[0] = 8'hE4;
        mem[4] = 8'hE7;
        mem[7] = 8'hE9;
        expect_instr(4'h0, 8'hE4);
        expect_instr(4'h4, 8'hE7);
        expect_instr(4'h7, 8'hE9);
        run_prog(4'h0, 50, to);
        checks++;
        if (to || fault !== 1'b1 || pc !== 4'h7 || state_out !== 3'd5) begin
            failures++;
            $display("FAIL overflow: got f%b pc %h s%0d want f1 pc 7 s5", fault, pc, state_out);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (state_out !== 3'd5 || imem_req !== 1'b0 || pc !== 4'h7) begin
            failures++;
            $display("FAIL fault_sticky: got s%0d req %b pc %h want s5 req 0 pc 7",
                     state_out, imem_req, pc);
        end
    endtask

    task automatic test_ret_empty();
        bit to;
        do_reset();
        fill_mem();
        mem[0] = 8'hF0;
        expect_instr(4'h0, 8'hF0);
        run_prog(4'h0, 50, to);
        checks++;
        if (to || fault !== 1'b1 || pc !== 4'h0) begin
            failures++;
            $display("FAIL ret_empty: got f%b pc %h want f1 pc 0", fault, pc);
        end
    endtask

    task automatic test_wait_wrap();
        bit to;
        do_reset();
        fill_mem();
        ack_delay = 3;
        mem[14] = 8'h9A;
        mem[15] = 8'h00;
        mem[0]  = 8'hFF;
        expect_instr(4'hE, 8'h9A);
        expect_instr(4'hF, 8'h00);
        expect_instr(4'h0, 8'hFF);
        run_prog(4'hE, 100, to);
        checks++;
        if (to || halted !== 1'b1 || pc !== 4'h0) begin
            failures++;
            $display("FAIL wait_wrap: got pc %h halted %b want pc 0 halted 1", pc, halted);
        end
        checks++;
        if (fetch_q.size() != 0 || exec_q.size() != 0) begin
            failures++;
            $display("FAIL wait_drain: got %0d/%0d want 0/0", fetch_q.size(), exec_q.size());
        end
        ack_delay = 0;
    endtask

    task automatic test_reset_mid_fetch();
        bit to;
        do_reset();
        fill_mem();
        ack_delay = 5;
        mem[4] = 8'hFF;
        @(negedge clk);
        start_address = 4'h9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_fetch_req: got %b want 1", imem_req);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || state_out !== 3'd0 || pc !== 4'h0) begin
            failures++;
            $display("FAIL async_reset: got req %b s%0d pc %h want req 0 s0 pc 0",
                     imem_req, state_out, pc);
        end
        fetch_q.delete();
        exec_q.delete();
        last_ir = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ack_delay = 0;
        expect_instr(4'h4, 8'hFF);
        run_prog(4'h4, 50, to);
        checks++;
        if (to || halted !== 1'b1 || pc !== 4'h4) begin
            failures++;
            $display("FAIL restart: got pc %h halted %b want pc 4 halted 1", pc, halted);
        end
        checks++;
        if (fetch_q.size() != 0 || exec_q.size() != 0) begin
            failures++;
            $display("FAIL restart_drain: got %0d/%0d want 0/0", fetch_q.size(), exec_q.size());
        end
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_program();
        test_branch();
        test_back_to_back();
        test_call_ret();
        test_stack_overflow();
        test_ret_empty();
        test_wait_wrap();
        test_reset_mid_fetch();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
